// File: rtl/my_clint.sv
// my_clint: RISC-V core-local interruptor (64-bit mtime, per-hart mtimecmp and msip) on a valid/ready bus.
// Build option CLINT_RTC_SYNC_EN inserts a 2-flop rt_clk synchronizer ahead of the edge detector.
module my_clint #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rt_clk,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip
);

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0]        addr_ext_s;
    logic               unused_addr_s;
    logic               is_write_s;
    logic               sel_msip_s;
    logic               sel_cmp_s;
    logic               sel_time_s;
    logic               word_hi_s;
    logic [3:0]         msip_hart_s;
    logic [3:0]         cmp_hart_s;
    logic               msip_wr_s;
    logic               cmp_wr_s;
    logic               time_wr_s;

    logic               rtc_sample_s;
    logic               rtc_prev_r;
    logic               rtc_tick_s;

    logic [63:0]        mtime_r;
    logic [63:0]        mtime_next_s;
    logic [63:0]        mtimecmp_r [N_CORES];
    logic [N_CORES-1:0] msip_r;
    logic [N_CORES-1:0] mtip_r;
    logic               ready_r;
    logic [31:0]        rdata_r;
    logic [31:0]        rd_word_s;

    // Decode: MSIP at 0x0000+4h, MTIMECMP at 0x4000+8h, MTIME at 0xBFF8.
    assign addr_ext_s    = 32'(address);
    assign unused_addr_s = ^addr_ext_s[1:0];
    assign is_write_s    = |wstrb;
    assign sel_msip_s    = (addr_ext_s[31:6] == 26'h0);
    assign sel_cmp_s     = (addr_ext_s[31:7] == 25'h80);
    assign sel_time_s    = (addr_ext_s[31:3] == 29'h17FF);
    assign word_hi_s     = addr_ext_s[2];
    assign msip_hart_s   = addr_ext_s[5:2];
    assign cmp_hart_s    = addr_ext_s[6:3];
    assign msip_wr_s     = valid & is_write_s & sel_msip_s;
    assign cmp_wr_s      = valid & is_write_s & sel_cmp_s;
    assign time_wr_s     = valid & is_write_s & sel_time_s;

`ifdef CLINT_RTC_SYNC_EN
    logic [1:0] rtc_sync_r;

    // Two-flop synchronizer for the asynchronous real-time clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            rtc_sync_r <= 2'b00;
        end else begin
            rtc_sync_r <= {rtc_sync_r[0], rt_clk};
        end
    end

    assign rtc_sample_s = rtc_sync_r[1];
`else
    assign rtc_sample_s = rt_clk;
`endif

    // Edge-detect flop: a tick is a 0->1 change of the sampled rt_clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            rtc_prev_r <= 1'b0;
        end else begin
            rtc_prev_r <= rtc_sample_s;
        end
    end

    assign rtc_tick_s = rtc_sample_s & ~rtc_prev_r;

    // Next mtime: a bus write to either half wins over (and drops) a same-cycle tick.
    always_comb begin
        mtime_next_s = mtime_r;
        if (time_wr_s && word_hi_s) begin
            mtime_next_s[63:32] = merge_bytes(mtime_r[63:32], wdata, wstrb);
        end else if (time_wr_s) begin
            mtime_next_s[31:0] = merge_bytes(mtime_r[31:0], wdata, wstrb);
        end else if (rtc_tick_s) begin
            mtime_next_s = mtime_r + 64'd1;
        end else begin
            mtime_next_s = mtime_r;
        end
    end

    // mtime register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_r <= 64'h0;
        end else begin
            mtime_r <= mtime_next_s;
        end
    end

    // Per-hart mtimecmp and msip registers with byte-strobed writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            msip_r <= {N_CORES{1'b0}};
            for (int h = 0; h < N_CORES; h++) begin
                mtimecmp_r[h] <= CMP_RESET;
            end
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                if (msip_wr_s && (msip_hart_s == h[3:0]) && wstrb[0]) begin
                    msip_r[h] <= wdata[0];
                end
                if (cmp_wr_s && (cmp_hart_s == h[3:0]) && word_hi_s) begin
                    mtimecmp_r[h][63:32] <= merge_bytes(mtimecmp_r[h][63:32], wdata, wstrb);
                end else if (cmp_wr_s && (cmp_hart_s == h[3:0])) begin
                    mtimecmp_r[h][31:0] <= merge_bytes(mtimecmp_r[h][31:0], wdata, wstrb);
                end
            end
        end
    end

    // Registered timer interrupt: unsigned 64-bit compare each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtip_r <= {N_CORES{1'b0}};
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                mtip_r[h] <= (mtime_r >= mtimecmp_r[h]);
            end
        end
    end

    // Read mux; unmapped offsets and harts beyond N_CORES read as zero.
    always_comb begin
        rd_word_s = 32'h0;
        for (int h = 0; h < N_CORES; h++) begin
            rd_word_s = rd_word_s |
                ((sel_msip_s && (msip_hart_s == h[3:0])) ? {31'h0, msip_r[h]} : 32'h0);
            rd_word_s = rd_word_s |
                ((sel_cmp_s && (cmp_hart_s == h[3:0])) ?
                    (word_hi_s ? mtimecmp_r[h][63:32] : mtimecmp_r[h][31:0]) : 32'h0);
        end
        rd_word_s = rd_word_s |
            (sel_time_s ? (word_hi_s ? mtime_r[63:32] : mtime_r[31:0]) : 32'h0);
    end

    // One-cycle response pulse; rdata held at zero outside the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'h0;
        end else begin
            ready_r <= valid;
            rdata_r <= valid ? rd_word_s : 32'h0;
        end
    end

    assign ready = ready_r;
    assign rdata = rdata_r;
    assign mtip  = mtip_r;
    assign msip  = msip_r;

endmodule

// File: tb/tb_my_clint.sv
// Directed self-checking bench for my_clint (single hart, rt_clk derived from clk).
module tb_my_clint;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rt_clk = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] address = 16'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] rdata;
    logic        ready;
    logic [0:0]  mtip;
    logic [0:0]  msip;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit rtc_en = 1'b0;
    int rtc_div = 0;
    int rtc_edges = 0;

    my_clint #(.ADDR_W(16), .DATA_W(32), .N_CORES(1)) dut (
        .clk(clk), .reset(reset), .rt_clk(rt_clk), .valid(valid),
        .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip)
    );

    always #5 clk = ~clk;

    // rt_clk: period of 8 clk cycles while enabled, changed away from clk edges
    always @(posedge clk) begin
        #3;
        if (rtc_en) begin
            if (rtc_div == 3) begin
                rtc_div = 0;
                rt_clk = ~rt_clk;
                if (rt_clk) rtc_edges = rtc_edges + 1;
            end else begin
                rtc_div = rtc_div + 1;
            end
        end else begin
            rtc_div = 0;
            rt_clk = 1'b0;
        end
    end

    task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic rdy, output logic [31:0] rd);
        @(posedge clk); #1;
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        valid = 1'b0; address = 16'h0; wdata = 32'h0; wstrb = 4'h0;
        @(negedge clk);
        rdy = ready;
        rd = rdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_edges(input int n, output bit ok);
        int base;
        base = rtc_edges;
        ok = 1'b0;
        rtc_en = 1'b1;
        for (int c = 0; c < 40 * n + 40; c++) begin
            @(negedge clk);
            if (rtc_edges - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        rtc_en = 1'b0;
        idle(8);
    endtask

    task automatic test_reset;
        logic rdy; logic [31:0] rd;
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({msip, mtip, ready} !== 3'b000 || rdata !== 32'h0)
            $display("FAIL reset_outputs: msip=%b mtip=%b ready=%b rdata=%h, need 0", msip, mtip, ready, rdata);
        else pass_cnt++;
        bus(16'h4000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rdy !== 1'b1 || rd !== 32'hFFFF_FFFF)
            $display("FAIL reset_cmp_lo: ready=%b rdata=%h, need 1 ffffffff", rdy, rd);
        else pass_cnt++;
        bus(16'hBFF8, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rdy !== 1'b1 || rd !== 32'h0)
            $display("FAIL reset_mtime_lo: ready=%b rdata=%h, need 1 00000000", rdy, rd);
        else pass_cnt++;
    endtask

    task automatic test_software_irq;
        logic rdy; logic [31:0] rd;
        bus(16'h0000, 32'h1, 4'hF, rdy, rd);
        total_cnt++;
        if (rdy !== 1'b1 || msip !== 1'b1)
            $display("FAIL msip_set: ready=%b msip=%b, need 1 1", rdy, msip);
        else pass_cnt++;
        bus(16'h0000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rd !== 32'h1) $display("FAIL msip_read1: rdata=%h, need 00000001", rd);
        else pass_cnt++;
        bus(16'h0000, 32'h0, 4'hF, rdy, rd);
        total_cnt++;
        if (msip !== 1'b0) $display("FAIL msip_clear: msip=%b, need 0", msip);
        else pass_cnt++;
        bus(16'h0000, 32'hFFFF_FFFF, 4'hF, rdy, rd);
        bus(16'h0000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rd !== 32'h1 || msip !== 1'b1)
            $display("FAIL msip_upper_bits: rdata=%h msip=%b, need 00000001 1", rd, msip);
        else pass_cnt++;
        bus(16'h0000, 32'h0, 4'h1, rdy, rd);
    endtask

    task automatic test_unmapped;
        logic rdy; logic [31:0] rd;
        bus(16'h2000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rdy !== 1'b1 || rd !== 32'h0)
            $display("FAIL unmapped_read: ready=%b rdata=%h, need 1 00000000", rdy, rd);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b0 || rdata !== 32'h0)
            $display("FAIL ready_pulse_len: ready=%b rdata=%h, need 0 00000000", ready, rdata);
        else pass_cnt++;
        bus(16'h2000, 32'hFFFF_FFFF, 4'hF, rdy, rd);
        bus(16'h4008, 32'h1234_5678, 4'hF, rdy, rd);
        bus(16'h4000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rd !== 32'hFFFF_FFFF || msip !== 1'b0)
            $display("FAIL unmapped_no_effect: cmp_lo=%h msip=%b, need ffffffff 0", rd, msip);
        else pass_cnt++;
        bus(16'h4008, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rdy !== 1'b1 || rd !== 32'h0)
            $display("FAIL absent_hart_read: ready=%b rdata=%h, need 1 00000000", rdy, rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic r1, r2, r3; logic [31:0] d1, d2;
        @(posedge clk); #1;
        valid = 1'b1; address = 16'h4004; wstrb = 4'h0;
        @(posedge clk); #1;
        address = 16'hBFFC;
        @(negedge clk);
        r1 = ready; d1 = rdata;
        @(posedge clk); #1;
        valid = 1'b0; address = 16'h0;
        @(negedge clk);
        r2 = ready; d2 = rdata;
        @(negedge clk);
        r3 = ready;
        total_cnt++;
        if ({r1, r2, r3} !== 3'b110 || d1 !== 32'hFFFF_FFFF || d2 !== 32'h0)
            $display("FAIL back_to_back: ready=%b%b%b d1=%h d2=%h, need 110 ffffffff 00000000",
                     r1, r2, r3, d1, d2);
        else pass_cnt++;
    endtask

    task automatic test_byte_strobes;
        logic rdy; logic [31:0] rd;
        bus(16'h4000, 32'hAABB_CCDD, 4'h3, rdy, rd);
        bus(16'h4000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rd !== 32'hFFFF_CCDD) $display("FAIL strobe_low: rdata=%h, need ffffccdd", rd);
        else pass_cnt++;
        bus(16'h4000, 32'h1122_3344, 4'h8, rdy, rd);
        bus(16'h4000, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rd !== 32'h11FF_CCDD || mtip !== 1'b0)
            $display("FAIL strobe_top: rdata=%h mtip=%b, need 11ffccdd 0", rd, mtip);
        else pass_cnt++;
        bus(16'h4000, 32'hFFFF_FFFF, 4'hF, rdy, rd);
    endtask

    task automatic test_mtime;
        logic rdy; logic [31:0] lo, hi; bit ok;
        run_edges(5, ok);
        bus(16'hBFF8, 32'h0, 4'h0, rdy, lo);
        bus(16'hBFFC, 32'h0, 4'h0, rdy, hi);
        total_cnt++;
        if (!ok || lo !== 32'd5 || hi !== 32'h0)
            $display("FAIL mtime_count: edges_ok=%0d mtime=%h_%h, need 00000000_00000005", ok, hi, lo);
        else pass_cnt++;
        bus(16'hBFFC, 32'h1, 4'hF, rdy, lo);
        bus(16'hBFF8, 32'h0, 4'h0, rdy, lo);
        bus(16'hBFFC, 32'h0, 4'h0, rdy, hi);
        total_cnt++;
        if (lo !== 32'd5 || hi !== 32'h1)
            $display("FAIL mtime_hi_write: mtime=%h_%h, need 00000001_00000005", hi, lo);
        else pass_cnt++;
        bus(16'hBFF8, 32'h0, 4'hF, rdy, lo);
        bus(16'hBFF8, 32'h0, 4'h0, rdy, lo);
        bus(16'hBFFC, 32'h0, 4'h0, rdy, hi);
        total_cnt++;
        if (lo !== 32'h0 || hi !== 32'h1)
            $display("FAIL mtime_lo_write: mtime=%h_%h, need 00000001_00000000", hi, lo);
        else pass_cnt++;
        bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, rdy, lo);
        bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, rdy, lo);
        idle(2);
        total_cnt++;
        if (mtip !== 1'b1) $display("FAIL mtip_equal_max: mtip=%b, need 1", mtip);
        else pass_cnt++;
        run_edges(1, ok);
        bus(16'hBFF8, 32'h0, 4'h0, rdy, lo);
        bus(16'hBFFC, 32'h0, 4'h0, rdy, hi);
        total_cnt++;
        if (!ok || lo !== 32'h0 || hi !== 32'h0 || mtip !== 1'b0)
            $display("FAIL mtime_wrap: mtime=%h_%h mtip=%b, need 00000000_00000000 0", hi, lo, mtip);
        else pass_cnt++;
    endtask

    task automatic test_timer_compare;
        logic rdy; logic [31:0] rd;
        int base, edge20, rise;
        bit early_bad, drop_bad;
        bus(16'hBFF8, 32'h0, 4'hF, rdy, rd);
        bus(16'hBFFC, 32'h0, 4'hF, rdy, rd);
        bus(16'h4000, 32'd20, 4'hF, rdy, rd);
        bus(16'h4004, 32'h0, 4'hF, rdy, rd);
        base = rtc_edges; edge20 = -1; rise = -1; early_bad = 1'b0; drop_bad = 1'b0;
        rtc_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rtc_edges - base < 20 && mtip !== 1'b0) early_bad = 1'b1;
            if (edge20 < 0 && rtc_edges - base >= 20) edge20 = c;
            if (rise >= 0 && mtip !== 1'b1) drop_bad = 1'b1;
            if (rise < 0 && mtip === 1'b1) rise = c;
            if (rtc_edges - base >= 23) break;
        end
        @(posedge clk); #1;
        rtc_en = 1'b0;
        idle(8);
        total_cnt++;
        if (early_bad) $display("FAIL mtip_early: mtip=1 before mtime reached 20, need 0");
        else pass_cnt++;
        total_cnt++;
        if (edge20 < 0 || rise - edge20 < 1 || rise - edge20 > 5)
            $display("FAIL mtip_rise: rise_cycle=%0d edge20_cycle=%0d, need lag 1..5", rise, edge20);
        else pass_cnt++;
        total_cnt++;
        if (drop_bad || mtip !== 1'b1) $display("FAIL mtip_hold: dropped=%0d mtip=%b, need 0 1", drop_bad, mtip);
        else pass_cnt++;
        bus(16'h4000, 32'hFFFF_FFFF, 4'hF, rdy, rd);
        @(negedge clk);
        total_cnt++;
        if (mtip !== 1'b0) $display("FAIL mtip_clear: mtip=%b, need 0", mtip);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic rdy; logic [31:0] rd;
        @(posedge clk); #1;
        valid = 1'b1; address = 16'h0000; wdata = 32'h1; wstrb = 4'hF; reset = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 4'h0; wdata = 32'h0; reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b0 || msip !== 1'b0 || mtip !== 1'b0)
            $display("FAIL reset_mid: ready=%b msip=%b mtip=%b, need 0 0 0", ready, msip, mtip);
        else pass_cnt++;
        bus(16'h4004, 32'h0, 4'h0, rdy, rd);
        total_cnt++;
        if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_mid_cmp: rdata=%h, need ffffffff", rd);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_software_irq();
        test_unmapped();
        test_back_to_back();
        test_byte_strobes();
        test_mtime();
        test_timer_compare();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/my_clint.md
Name: my_clint

Overview:
- RISC-V Core-Local Interruptor (CLINT) for up to N_CORES harts.
- Provides a 64-bit real-time counter (mtime), one 64-bit compare register per hart (mtimecmp), and one software-interrupt bit per hart (msip).
- Drives per-hart machine timer (mtip) and machine software (msip) interrupt lines.
- Sits on the CPU's native valid/ready peripheral bus.

Parameters:
- ADDR_W, 16, bus byte-address width.
- DATA_W, 32, bus data width. Only 32 is supported.
- N_CORES, 1, number of harts (1..16).

Ports:
- clk  input  1  system clock; all logic is in this domain.
- reset  input  1  synchronous, active-high reset.
- rt_clk  input  1  real-time clock, asynchronous to clk, much slower than clk.
- valid  input  1  request strobe.
- address  input  ADDR_W  byte address; bits [1:0] are ignored.
- wdata  input  DATA_W  write data.
- wstrb  input  DATA_W/8  byte write enables; all zero means a read.
- rdata  output  DATA_W  read data, valid while ready=1.
- ready  output  1  one-cycle response pulse.
- mtip  output  N_CORES  machine timer interrupt per hart.
- msip  output  N_CORES  machine software interrupt per hart.

Behaviour:
- Address map (byte offsets):
  - MSIP[h] at 0x0000+4h: bit0 is R/W; other bits read 0.
  - MTIMECMP[h] at 0x4000+8h (low word) and +8h+4 (high word).
  - MTIME at 0xBFF8 (low word) and 0xBFFC (high word).
  - Any other address: reads return 0, writes are ignored, and ready is still returned.
- Handshake:
  - A request is sampled on a clk edge when valid=1.
  - ready=1 exactly one cycle later, for one cycle; rdata is valid in that cycle.
  - Write effects are visible from the cycle in which ready is high.
  - valid may drop after one cycle.
  - Back-to-back requests are allowed; each gets its own ready pulse.
  - rdata is 0 when ready=0.
- Byte writes: each set wstrb[i] updates byte i of the addressed 32-bit word. Reads never modify state.
- mtime:
  - 64-bit counter, incremented by 1 per rising edge of rt_clk.
  - The edge is detected in the clk domain: a registered previous value of the rt_clk sample, compared with the current sample.
  - Wraps from 2^64-1 to 0.
  - Each 32-bit half is writable independently; no carry is applied between halves on a write.
  - If a bus write and an increment occur in the same cycle, the written value wins and that increment is dropped.
- mtip[h]:
  - Registered; mtip[h] = (mtime >= mtimecmp[h]) as an unsigned 64-bit compare, re-evaluated every clk cycle.
  - Update lag is at most 1 cycle after mtime or mtimecmp changes.
  - Level-sensitive: stays high until mtimecmp is raised or mtime is reduced.
- msip[h]: driven directly from the MSIP[h] bit0 register.
- Reset values:
  - mtime = 0.
  - mtimecmp[h] = 64'hFFFF_FFFF_FFFF_FFFF, so no timer interrupt fires out of reset.
  - msip = 0, mtip = 0, ready = 0, rdata = 0.
  - rt_clk synchronizer and edge-detect flops = 0.
- Reset mid-operation:
  - An in-flight request is discarded and no ready is issued for it.
  - All state returns to reset values on the next edge.

Optional Feature:
- Macro: CLINT_RTC_SYNC_EN.
- Defined: rt_clk passes through a 2-flop synchronizer before edge detection, giving 3-4 clk cycles of latency from an rt_clk rising edge to the mtime increment. This is required when rt_clk is truly asynchronous.
- Undefined: rt_clk is sampled by a single edge-detect flop, with a 1-cycle latency to the increment. rt_clk must then be generated synchronously to clk.
- The register map and all bus behaviour are identical in both builds.

Test Plan:
- Reset: hold reset 100 cycles, then release. Required: msip=0, mtip=0, ready=0. A read of 0x4000 returns 0xFFFFFFFF; a read of 0xBFF8 returns 0 before the first rt_clk edge.
- Timer compare:
  - Stimulus: write 0x4000=20 and 0x4004=0, wstrb=0xF.
  - Required: mtip[0]=0 while mtime<20; mtip[0] rises within 1 cycle after mtime reaches 20 and stays high.
  - Then write 0x4000=0xFFFFFFFF. Required: mtip[0] clears.
- Software interrupt: write 0x0000=1. Required: msip[0]=1 in the ready cycle. Write 0x0000=0. Required: msip[0]=0. A read of 0x0000 returns the bit.
- mtime read/write:
  - Stimulus: read 0xBFF8 then 0xBFFC after N rt_clk edges. Required: the combined value equals N, or N+1 if a tick falls between the two reads.
  - Stimulus: write 0xBFF8=0. Required: the next low-word read is small (counting restarted), and the high word is unchanged.
- Byte strobes: write 0x4000=0xAABBCCDD with wstrb=0x3 over 0xFFFFFFFF. Required: a read returns 0xFFFFCCDD.
- Handshake and unmapped address: valid pulse to 0x2000. Required: ready exactly one cycle later with rdata=0 and no state change. Two consecutive requests produce two ready pulses.
